tx_frame_arbiter: RTL
=====================

// Module: tx_frame_arbiter
// PURPOSE
//   Round-robin arbiter that shares the single MAC transmit datapath among
//   NO_INPUTS frame sources. Grants one source at a time for a whole frame.
//   Holds the grant until end-of-frame, then enforces an inter-frame gap.
//   Sits between the per-source TX queues and the TX framer; grant drives the data mux select.
// PARAMETERS
//   NO_INPUTS   4     number of requesting sources (>=2)
//   IFG_CYCLES  12    idle cycles inserted after every frame end/abort (0 allowed)
//   MAX_CYCLES  2048  watchdog: max grant length in cycles before forced abort (>=2)
// PORTS
//   clk        in   1          system clock
//   reset      in   1          synchronous, active-high reset
//   enable     in   1          0 = issue no new grants; a frame in progress completes
//   req        in   NO_INPUTS  per-source frame-pending request (level)
//   eof        in   1          last beat of granted frame; only sampled in BUSY
//   grant      out  NO_INPUTS  one-hot grant, all-zero when no owner
//   grant_id   out  $clog2(NO_INPUTS)  binary index of current/last owner
//   busy       out  1          high while a grant is held (BUSY state)
//   done       out  1          1-cycle pulse: frame ended normally via eof
//   abort      out  1          1-cycle pulse: frame ended via req drop or watchdog
// BEHAVIOUR
//   Reset: state=IDLE, grant=0, grant_id=0, busy=0, done=0, abort=0,
//     rr pointer=0 (source 0 highest priority), counters=0. Reset mid-frame
//     drops grant on the next edge; no done/abort is produced.
//   States: IDLE, BUSY, GAP.
//   IDLE: if enable && |req -> winner = first set req[i] scanning
//     i = ptr, ptr+1, ... ptr+NO_INPUTS-1 (mod NO_INPUTS); next cycle grant=1<<winner,
//     grant_id=winner, busy=1, ptr=(winner+1) mod NO_INPUTS, state=BUSY.
//     Latency: req seen at edge k -> grant valid after edge k+1. No req/enable: stay IDLE.
//   BUSY: grant stable; cycle counter increments from 1 each cycle.
//     eof=1 -> done pulse, grant=0, busy=0 on next edge; go GAP.
//     req[grant_id]=0 with eof=0 -> abort pulse, same release; go GAP.
//     eof and req drop same cycle -> treated as eof (done, no abort).
//     counter reaches MAX_CYCLES with no eof -> abort pulse, release, GAP.
//     enable and other req changes ignored in BUSY.
//   GAP: grant=0; count IFG_CYCLES cycles, then IDLE. IFG_CYCLES=0 -> BUSY
//     exits straight to IDLE (one IDLE cycle still required before the next grant).
//   done/abort are registered, high exactly one cycle, coincident with grant falling.
//   Pointer wraps NO_INPUTS-1 -> 0. grant_id retains last owner when grant=0.
//   Grant is never multi-hot; at most one owner at any cycle.
// TESTING  (NO_INPUTS=4, IFG_CYCLES=2, MAX_CYCLES=16)
//   1 Reset, req=4'b1010, enable=1 -> grant=4'b0010 one cycle later, grant_id=1, busy=1.
//   2 All req=4'b1111 held, eof after 3 beats each -> grant order 0,1,2,3,0; 2 zero-grant
//     cycles + 1 IDLE cycle between frames; done pulses once per frame.
//   3 Granted source drops req mid-frame (no eof) -> abort=1 one cycle, grant=0, done=0.
//   4 Granted req held 16 cycles with no eof -> abort at cycle 16, next owner after gap.
//   5 enable=0 while BUSY -> frame completes with done; no further grant until enable=1.
//   6 reset asserted in BUSY -> grant=0, busy=0, ptr=0 next edge, no done/abort pulse.

Source files
------------

// File: rtl/tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_frame_arbiter
// Purpose  : Round-robin, frame-granular arbiter for the shared MAC TX path,
//            with a watchdog on grant length and an inter-frame gap.
// Revision : 1.0
// ============================================================================
module tx_frame_arbiter #(
    parameter int NO_INPUTS  = 4,
    parameter int IFG_CYCLES = 12,
    parameter int MAX_CYCLES = 2048
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [NO_INPUTS-1:0]         req,
    input  logic                         eof,
    output logic [NO_INPUTS-1:0]         grant,
    output logic [$clog2(NO_INPUTS)-1:0] grant_id,
    output logic                         busy,
    output logic                         done,
    output logic                         abort
);

    localparam int IW = $clog2(NO_INPUTS);
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam int GW = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;
    localparam logic [NO_INPUTS-1:0] C_ONE = {{(NO_INPUTS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t        r_state;
    logic [IW-1:0] r_ptr;
    logic [CW-1:0] r_cnt;
    logic [GW-1:0] r_gap;
    logic [IW-1:0] w_winner;
    logic          w_found;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NO_INPUTS) s = s - NO_INPUTS;
        return IW'(s);
    endfunction

    // Scan from the highest offset down so the lowest offset past ptr wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int off = NO_INPUTS - 1; off >= 0; off--) begin
            if (req[wrap_idx(r_ptr, off)]) begin
                w_found  = 1'b1;
                w_winner = wrap_idx(r_ptr, off);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_gap    <= '0;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            abort    <= 1'b0;
        end else begin
            done  <= 1'b0;
            abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable && w_found) begin
                        grant    <= C_ONE << w_winner;
                        grant_id <= w_winner;
                        busy     <= 1'b1;
                        r_ptr    <= wrap_idx(w_winner, 1);
                        r_cnt    <= CW'(1);
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // eof has priority over a simultaneous request drop or timeout.
                    if (eof || !req[grant_id] || (r_cnt == CW'(MAX_CYCLES))) begin
                        grant   <= '0;
                        busy    <= 1'b0;
                        done    <= eof;
                        abort   <= !eof;
                        r_gap   <= GW'(1);
                        r_state <= (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_gap == GW'(IFG_CYCLES)) r_state <= S_IDLE;
                    else                          r_gap   <= r_gap + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
